// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator.
package csa_pkg;

    // Controller states: take beats, resolve the carry-save total, hold the result.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    // Widest accumulator the extension helper supports.
    localparam int EXT_MAX = 64;

    // Extends the low 'width' bits of data to EXT_MAX bits, sign- or zero-filled.
    // Callers truncate the result to their own accumulator width.
    function automatic logic [EXT_MAX-1:0] ext_operand(
        input logic [EXT_MAX-1:0] data,
        input int                 width,
        input logic               is_signed
    );
        logic [EXT_MAX-1:0] result;
        logic               fill;
        fill = 1'b0;
        for (int i = 0; i < EXT_MAX; i++) begin
            if (i == width - 1) begin
                fill = is_signed & data[i];
            end
        end
        for (int i = 0; i < EXT_MAX; i++) begin
            result[i] = (i < width) ? data[i] : fill;
        end
        return result;
    endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand stream in, frame result out, both with valid/ready handshakes.
interface csa_accumulator_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = WIDTH + 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_first;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_ovf;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_data, in_first, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/csa_accumulator_csa.sv
// 3:2 carry-save compressor: per-bit full adders with no carry propagation.
module csa_accumulator_csa #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    // Sum bit is the parity of the three inputs; carry is their majority
    // (carry[i] carries weight 2^(i+1), the caller shifts it).
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator holding the running total as sum/carry
// vectors; a single carry-propagate add resolves it at the end of a frame.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = WIDTH + 8,
    parameter int SIGNED    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    csa_accumulator_if.slave bus
);

    localparam int GUARD = ACC_WIDTH - WIDTH;
    localparam int CNT_W = GUARD + 2;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(1) << GUARD;
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_LIMIT + CNT_W'(1);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] s_q, s_d;
    logic [ACC_WIDTH-1:0] c_q, c_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic                 out_ovf_q, out_ovf_d;

    logic                 accept;
    logic                 first_beat;
    logic [ACC_WIDTH-1:0] ext_val;
    logic [ACC_WIDTH-1:0] s_base;
    logic [ACC_WIDTH-1:0] c_base;
    logic [ACC_WIDTH-1:0] csa_sum;
    logic [ACC_WIDTH-1:0] csa_carry;

    // Ready comes from registered state only, so out_ready never reaches in_ready.
    assign bus.in_ready  = rst_n && ((state_q == IDLE) || (state_q == ACCUM));
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;

    // Select the compressor inputs: a first beat starts from a zero total.
    always_comb begin
        accept     = bus.in_valid && bus.in_ready;
        first_beat = bus.in_first || (state_q == IDLE);
        ext_val    = ACC_WIDTH'(ext_operand(EXT_MAX'(bus.in_data), WIDTH, SIGNED != 0));
        s_base     = first_beat ? '0 : s_q;
        c_base     = first_beat ? '0 : c_q;
    end

    csa_accumulator_csa #(
        .WIDTH(ACC_WIDTH)
    ) u_csa (
        .a    (s_base),
        .b    (c_base << 1),
        .c    (ext_val),
        .sum  (csa_sum),
        .carry(csa_carry)
    );

    // Next-state, datapath and output updates for the frame controller.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    s_d = csa_sum;
                    c_d = csa_carry;
                    if (first_beat) begin
                        count_d = CNT_W'(1);
                    end else if (count_q != CNT_SAT) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    state_d = bus.in_last ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: begin
                out_sum_d   = s_q + (c_q << 1);
                out_ovf_d   = (count_q > CNT_LIMIT);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Testbench: an unsigned and a signed accumulator receive the same stream and
// are compared against a frame-sum model built from plain integer arithmetic.
module tb_csa_accumulator;

    localparam int W    = 16;
    localparam int AW   = 24;
    localparam int BEAT_LIMIT = 256;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    // Reference model state: running frame sums as wide integers.
    bit     model_open;
    longint acc_u;
    longint acc_s;
    int     nbeats;

    csa_accumulator_if #(.WIDTH(W), .ACC_WIDTH(AW)) ifu ();
    csa_accumulator_if #(.WIDTH(W), .ACC_WIDTH(AW)) ifs ();

    csa_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(0)) dut_u (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifu.slave)
    );

    csa_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(1)) dut_s (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifs.slave)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setInputs(input logic v, input logic [W-1:0] d, input logic f, input logic l);
        ifu.in_valid = v; ifu.in_data = d; ifu.in_first = f; ifu.in_last = l;
        ifs.in_valid = v; ifs.in_data = d; ifs.in_first = f; ifs.in_last = l;
    endtask

    task automatic setOutReady(input logic r);
        ifu.out_ready = r;
        ifs.out_ready = r;
    endtask

    // Present one beat (called at a negedge) and wait for it to be taken.
    task automatic applyStimulus(input logic [W-1:0] d, input logic f, input logic l);
        int     waited;
        longint sv;
        setInputs(1'b1, d, f, l);
        waited = 0;
        while (!(ifu.in_ready && ifs.in_ready) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checkVal("beat_accept_timeout", 32'(waited), 32'(0));
        end
        @(posedge clk);
        if (f || !model_open) begin
            acc_u  = 0;
            acc_s  = 0;
            nbeats = 0;
        end
        model_open = 1'b1;
        sv = longint'($signed(d));
        acc_u  = acc_u + longint'(d);
        acc_s  = acc_s + sv;
        nbeats = nbeats + 1;
        @(negedge clk);
    endtask

    // Called at the negedge just after the last-beat edge. Checks the resolve
    // cycle, the held result for 'hold' extra cycles, and the output transfer.
    task automatic checkOutput(input int hold, input logic poke);
        logic [AW-1:0] exp_u;
        logic [AW-1:0] exp_s;
        logic          exp_ovf;
        exp_u   = acc_u[AW-1:0];
        exp_s   = acc_s[AW-1:0];
        exp_ovf = (nbeats > BEAT_LIMIT);
        if (poke) setInputs(1'b1, 16'hAAAA, 1'b1, 1'b1);
        else      setInputs(1'b0, '0, 1'b0, 1'b0);
        checkVal("resolve_out_valid_u", 32'(ifu.out_valid), 32'(0));
        checkVal("resolve_in_ready_u", 32'(ifu.in_ready), 32'(0));
        checkVal("resolve_out_valid_s", 32'(ifs.out_valid), 32'(0));
        @(negedge clk);
        for (int k = 0; k <= hold; k++) begin
            checkVal("hold_out_valid_u", 32'(ifu.out_valid), 32'(1));
            checkVal("hold_in_ready_u", 32'(ifu.in_ready), 32'(0));
            checkVal("hold_sum_u", 32'(ifu.out_sum), 32'(exp_u));
            checkVal("hold_ovf_u", 32'(ifu.out_ovf), 32'(exp_ovf));
            checkVal("hold_out_valid_s", 32'(ifs.out_valid), 32'(1));
            checkVal("hold_in_ready_s", 32'(ifs.in_ready), 32'(0));
            checkVal("hold_sum_s", 32'(ifs.out_sum), 32'(exp_s));
            checkVal("hold_ovf_s", 32'(ifs.out_ovf), 32'(exp_ovf));
            if (k < hold) @(negedge clk);
        end
        setOutReady(1'b1);
        @(posedge clk);
        @(negedge clk);
        setOutReady(1'b0);
        setInputs(1'b0, '0, 1'b0, 1'b0);
        model_open = 1'b0;
        checkVal("xfer_out_valid_u", 32'(ifu.out_valid), 32'(0));
        checkVal("xfer_in_ready_u", 32'(ifu.in_ready), 32'(1));
        checkVal("xfer_out_valid_s", 32'(ifs.out_valid), 32'(0));
        checkVal("xfer_in_ready_s", 32'(ifs.in_ready), 32'(1));
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_out_valid"}, 32'(ifu.out_valid), 32'(0));
        checkVal({tag, "_out_sum"}, 32'(ifu.out_sum), 32'(0));
        checkVal({tag, "_out_ovf"}, 32'(ifu.out_ovf), 32'(0));
        checkVal({tag, "_in_ready"}, 32'(ifu.in_ready), 32'(0));
        checkVal({tag, "_out_valid_s"}, 32'(ifs.out_valid), 32'(0));
        checkVal({tag, "_out_sum_s"}, 32'(ifs.out_sum), 32'(0));
    endtask

    // Directed scenarios followed by random frames.
    initial begin
        int len;
        int hold;
        n_checks   = 0;
        n_fail     = 0;
        model_open = 1'b0;
        acc_u      = 0;
        acc_s      = 0;
        nbeats     = 0;
        rst_n      = 1'b0;
        setInputs(1'b0, '0, 1'b0, 1'b0);
        setOutReady(1'b0);

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("post_reset_in_ready", 32'(ifu.in_ready), 32'(1));

        $display("[TB] three-beat frame");
        applyStimulus(16'h0001, 1'b1, 1'b0);
        applyStimulus(16'h0002, 1'b0, 1'b0);
        applyStimulus(16'h0003, 1'b0, 1'b1);
        checkVal("three_beat_model", 32'(acc_u[AW-1:0]), 32'h000006);
        checkOutput(0, 1'b0);

        $display("[TB] 256 and 257 beats of 0xFFFF");
        for (int i = 0; i < 256; i++) applyStimulus(16'hFFFF, i == 0, i == 255);
        checkOutput(0, 1'b0);
        for (int i = 0; i < 257; i++) applyStimulus(16'hFFFF, i == 0, i == 256);
        checkVal("257_model", 32'(acc_u[AW-1:0]), 32'h00FEFF);
        checkOutput(0, 1'b0);

        $display("[TB] sign handling");
        applyStimulus(16'hFFFF, 1'b1, 1'b0);
        applyStimulus(16'h0003, 1'b0, 1'b1);
        checkOutput(0, 1'b0);

        $display("[TB] held output with beat presented during hold");
        applyStimulus(16'h1234, 1'b1, 1'b1);
        checkOutput(5, 1'b1);
        applyStimulus(16'h0005, 1'b0, 1'b1);
        checkOutput(0, 1'b0);

        $display("[TB] restart inside a frame");
        applyStimulus(16'h0010, 1'b1, 1'b0);
        applyStimulus(16'h0020, 1'b0, 1'b0);
        applyStimulus(16'h0005, 1'b1, 1'b0);
        applyStimulus(16'h0001, 1'b0, 1'b1);
        checkVal("restart_model", 32'(acc_u[AW-1:0]), 32'h000006);
        checkOutput(0, 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(16'h0100, 1'b1, 1'b0);
        applyStimulus(16'h0200, 1'b0, 1'b0);
        setInputs(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_open = 1'b0;
        checkResetState("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h0007, 1'b0, 1'b1);
        checkOutput(0, 1'b0);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            len  = $urandom_range(1, 6);
            hold = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                applyStimulus(16'($urandom), i == 0, i == len - 1);
            end
            checkOutput(hold, 1'b0);
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Streaming multi-operand accumulator that keeps its running total in carry-save form, so each accepted operand costs one 3:2 compression with no carry propagation. A single carry-propagate add resolves the total once a frame ends. It generalises the fixed 3-operand compressor to an arbitrary-length operand stream and adds:

- valid/ready handshakes on input and output
- frame delimiting
- sign handling
- overflow detection

It sits between operand producers (partial-product or dot-product streams) and result consumers in the arithmetic datapath.

## Interface

Parameters:

- WIDTH, 16: input operand width.
- ACC_WIDTH, WIDTH+8: accumulator and result width. Must satisfy ACC_WIDTH > WIDTH. GUARD = ACC_WIDTH-WIDTH.
- SIGNED, 0: 1 = sign-extend operands to ACC_WIDTH; 0 = zero-extend.

Ports (one clock; reset is synchronous and active-low):

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  accumulator can accept a beat.
- in_data  in  WIDTH  operand.
- in_first  in  1  beat starts a new frame; clears the running total before adding.
- in_last  in  1  beat ends the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_WIDTH  frame sum, mod 2^ACC_WIDTH.
- out_ovf  out  1  frame had more than 2^GUARD beats.

## Operation

States:

- IDLE: in_ready=1. Any accepted beat is treated as first regardless of in_first. Accepted beat: without in_last → ACCUM; with in_last → RESOLVE.
- ACCUM: in_ready=1. Accepted beat with in_last → RESOLVE; without in_last → stay in ACCUM.
- RESOLVE: in_ready=0. out_sum <= S + (C<<1). out_ovf <= flag. out_valid <= 1. Go to HOLD.
- HOLD: in_ready=0. out_valid=1. out_sum and out_ovf are held stable. Transfer when out_ready=1 → IDLE, out_valid <= 0.

Datapath on each accepted beat (in_valid && in_ready):

- New values: (S, C) <= csa(S', {C'[ACC_WIDTH-2:0], 1'b0}, ext(in_data)).
- S' and C' are zero when the beat is first (in_first=1, or state is IDLE); otherwise they are the current registers.
- The carry bit shifted out of the top is discarded. All arithmetic is mod 2^ACC_WIDTH.

Beat counter:

- Set to 1 on a first beat; otherwise increments per beat.
- Saturates at 2^GUARD+1.
- Flag = (count > 2^GUARD).

Boundary cases:

- in_first && in_last on the same beat: single-beat frame; out_sum = ext(in_data).
- in_first in ACCUM: the previous partial frame is discarded silently; the new frame starts with this beat.
- in_valid while in_ready=0: the beat is ignored, and the producer must hold it.
- rst_n=0 at any point (mid-frame, RESOLVE or HOLD): all state is cleared at the next edge, and the partial frame is lost.

Reset values: state=IDLE, S=C=0, count=0, out_valid=0, out_sum=0, out_ovf=0. in_ready is forced to 0 while rst_n=0.

## Timing

- One beat per cycle is sustained in IDLE/ACCUM; there is no bubble between beats of a frame.
- Last beat accepted at edge E: RESOLVE during cycle E..E+1; out_valid=1 from edge E+1.
- Output transfer at edge T: out_valid=0 and in_ready=1 from edge T.
- The minimum frame-to-frame gap is 2 cycles (RESOLVE plus at least one HOLD cycle). Frames never overlap.
- in_ready depends only on the registered state; there is no combinational path from out_ready to in_ready.
- The critical path is one 3:2 level plus the input mux. The ACC_WIDTH-bit CPA is confined to the RESOLVE cycle.

## Structure

- Shared package csa_pkg holds:
  - the state enum (IDLE, ACCUM, RESOLVE, HOLD)
  - a function ext_operand(data, signed) returning ACC_WIDTH bits.
- One sub-module: the team's existing csa 3:2 compressor, instantiated with width=ACC_WIDTH.
- The CPA is a plain behavioural add in RESOLVE.

## Test plan

All scenarios use WIDTH=16, ACC_WIDTH=24 (GUARD=8) unless noted.

- Three beats 0x0001, 0x0002, 0x0003 (first/last framed) → out_sum=0x000006, out_ovf=0, out_valid rises one edge after the last-beat edge.
- 256 beats of 0xFFFF → out_sum=0xFFFF00, out_ovf=0. With 257 beats → out_sum=0x00FEFF, out_ovf=1.
- SIGNED=1, beats 0xFFFF then 0x0003 → out_sum=0x000002. SIGNED=0 with the same beats → 0x010002.
- out_ready held low 5 cycles after out_valid → out_sum and out_valid stable, in_ready=0 throughout. A beat presented during HOLD is not consumed. Single beat with first&last, 0x1234 → out_sum=0x001234.
- Beats 0x0010, 0x0020, then 0x0005 with in_first, then 0x0001 with in_last → out_sum=0x000006.
- rst_n low for one cycle mid-frame after beats 0x0100, 0x0200, then a new frame 0x0007 (last) → out_sum=0x000007, out_ovf=0. All outputs are at reset values in the cycle after the reset edge.
